// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : Memory-access stage between EX and WB. Drives a synchronous-read
//            data memory, range-checks addresses and counts loads/stores.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int MEM_DEPTH = 6536,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_load,
    input  logic             ex_is_store,
    input  logic [31:0]      ex_addr,
    input  logic [31:0]      ex_store_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_datain,
    input  logic [31:0]      mem_dataout,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [4:0]       wb_rd,
    output logic             wb_regwrite,
    output logic             wb_error,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    localparam logic [31:0]      C_MEM_DEPTH = 32'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_wb_valid;
    logic [31:0]     r_wb_data;
    logic [4:0]      r_wb_rd;
    logic            r_wb_regwrite;
    logic            r_wb_error;
    logic [4:0]      r_ld_rd;
    logic [CNT_W-1:0] r_load_count;
    logic [CNT_W-1:0] r_store_count;

    logic            w_ex_ready;
    logic            w_accept;
    logic            w_in_range;
    logic            w_load_ok;
    logic            w_store_ok;
    logic            w_err;

    assign w_ex_ready = (r_state == S_IDLE) && (!r_wb_valid || wb_ready);
    assign w_accept   = ex_valid && w_ex_ready;
    assign w_in_range = ex_addr < C_MEM_DEPTH;
    assign w_load_ok  = ex_is_load && !ex_is_store && w_in_range;
    assign w_store_ok = ex_is_store && !ex_is_load && w_in_range;
    // Range only matters for memory ops; a pass-through address is an ALU value.
    assign w_err      = (ex_is_load && ex_is_store) ||
                        ((ex_is_load || ex_is_store) && !w_in_range);

    assign ex_ready    = w_ex_ready;
    assign mem_read    = reset_n && w_accept && w_load_ok;
    assign mem_write   = reset_n && w_accept && w_store_ok;
    assign mem_address = w_accept ? ex_addr : 32'd0;
    assign mem_datain  = w_accept ? ex_store_data : 32'd0;

    assign wb_valid    = r_wb_valid;
    assign wb_data     = r_wb_data;
    assign wb_rd       = r_wb_rd;
    assign wb_regwrite = r_wb_regwrite;
    assign wb_error    = r_wb_error;
    assign load_count  = r_load_count;
    assign store_count = r_store_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_accept && w_load_ok) w_state_nxt = S_LOAD_WAIT;
            S_LOAD_WAIT: w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_valid    <= 1'b0;
            r_wb_data     <= 32'd0;
            r_wb_rd       <= 5'd0;
            r_wb_regwrite <= 1'b0;
            r_wb_error    <= 1'b0;
            r_ld_rd       <= 5'd0;
            r_load_count  <= '0;
            r_store_count <= '0;
        end else begin
            // The slot is always empty here: a load is only accepted when it drains.
            if (r_state == S_LOAD_WAIT) begin
                r_wb_valid    <= 1'b1;
                r_wb_data     <= mem_dataout;
                r_wb_rd       <= r_ld_rd;
                r_wb_regwrite <= 1'b1;
                r_wb_error    <= 1'b0;
                if (r_load_count != C_CNT_MAX) r_load_count <= r_load_count + 1'b1;
            end else if (w_accept && !w_load_ok) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= ex_rd;
                if (w_err) begin
                    r_wb_data     <= 32'd0;
                    r_wb_regwrite <= 1'b0;
                    r_wb_error    <= 1'b1;
                end else if (w_store_ok) begin
                    r_wb_data     <= 32'd0;
                    r_wb_regwrite <= 1'b0;
                    r_wb_error    <= 1'b0;
                    if (r_store_count != C_CNT_MAX) r_store_count <= r_store_count + 1'b1;
                end else begin
                    r_wb_data     <= ex_addr;
                    r_wb_regwrite <= ex_regwrite;
                    r_wb_error    <= 1'b0;
                end
            end else if (r_wb_valid && wb_ready) begin
                r_wb_valid <= 1'b0;
            end

            if (w_accept && w_load_ok) r_ld_rd <= ex_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Purpose  : Self-checking bench: directed scenarios plus random ops against a
//            word-array reference model. Counters use a narrow width.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    localparam int MEM_DEPTH = 6536;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             ex_valid, ex_ready, ex_is_load, ex_is_store, ex_regwrite;
    logic [31:0]      ex_addr, ex_store_data;
    logic [4:0]       ex_rd;
    logic             mem_read, mem_write;
    logic [31:0]      mem_address, mem_datain;
    logic [31:0]      mem_dataout;
    logic             wb_valid, wb_ready, wb_regwrite, wb_error;
    logic [31:0]      wb_data;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] load_count, store_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem     [0:MEM_DEPTH-1];
    logic [31:0] ref_mem [0:MEM_DEPTH-1];
    int          ref_ld = 0;
    int          ref_st = 0;

    lsu_mem_stage #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_error(wb_error),
        .load_count(load_count), .store_count(store_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read data memory seen by the DUT.
    always @(posedge clock) begin
        if (mem_write && mem_address < MEM_DEPTH) mem[mem_address[12:0]] <= mem_datain;
        if (mem_read && mem_address < MEM_DEPTH) mem_dataout <= mem[mem_address[12:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
        ex_addr = 0; ex_store_data = 0; ex_rd = 0; ex_regwrite = 0;
    endtask

    // One op through the stage with wb_ready=1; expectations come from the model.
    task automatic do_op(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input logic rw);
        logic        in_rng, lok, sok, err;
        logic [31:0] exp_data;
        logic        exp_rw;
        int          waitc;
        in_rng = addr < MEM_DEPTH;
        lok = ld && !st && in_rng;
        sok = st && !ld && in_rng;
        err = (ld && st) || ((ld || st) && !in_rng);
        @(posedge clock); #1;
        wb_ready = 1;
        ex_valid = 1; ex_is_load = ld; ex_is_store = st;
        ex_addr = addr; ex_store_data = data; ex_rd = rd; ex_regwrite = rw;
        waitc = 0;
        @(negedge clock);
        while (!ex_ready && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        check("accept_ready", {31'd0, ex_ready}, 32'd1);
        check("mem_read", {31'd0, mem_read}, {31'd0, lok});
        check("mem_write", {31'd0, mem_write}, {31'd0, sok});
        if (lok || sok) check("mem_address", mem_address, addr);
        if (sok) check("mem_datain", mem_datain, data);
        @(posedge clock); #1;
        idle_inputs();
        if (lok) begin
            @(negedge clock);
            check("lw_ex_ready", {31'd0, ex_ready}, 32'd0);
            check("lw_wb_valid", {31'd0, wb_valid}, 32'd0);
            check("lw_mem_read", {31'd0, mem_read}, 32'd0);
            @(posedge clock); #1;
        end
        exp_data = lok ? ref_mem[addr[12:0]] : ((err || sok) ? 32'd0 : addr);
        exp_rw   = lok ? 1'b1 : ((err || sok) ? 1'b0 : rw);
        if (sok) begin
            ref_mem[addr[12:0]] = data;
            ref_st = sat_inc(ref_st);
        end
        if (lok) ref_ld = sat_inc(ref_ld);
        @(negedge clock);
        check("wb_valid", {31'd0, wb_valid}, 32'd1);
        check("wb_data", wb_data, exp_data);
        check("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
        check("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, exp_rw});
        check("wb_error", {31'd0, wb_error}, {31'd0, err});
        check("load_count", 32'(load_count), 32'(ref_ld));
        check("store_count", 32'(store_count), 32'(ref_st));
    endtask

    initial begin
        logic [31:0] pre [0:5];
        logic [31:0] held_data;
        logic        ld, st;
        logic [31:0] a;
        pre[0] = 0; pre[1] = 4; pre[2] = 30; pre[3] = 19; pre[4] = 6; pre[5] = 10;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i]     = (i < 6) ? pre[i] : $urandom;
            ref_mem[i] = mem[i];
        end
        mem_dataout = 0;
        wb_ready = 1;
        idle_inputs();

        // Reset: strobes forced low even with a valid load presented.
        reset_n = 0;
        ex_valid = 1; ex_is_load = 1; ex_addr = 2;
        #12;
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_store_count", 32'(store_count), 32'd0);
        idle_inputs();
        @(negedge clock); reset_n = 1;
        @(negedge clock);
        check("idle_ex_ready", {31'd0, ex_ready}, 32'd1);
        check("idle_mem_address", mem_address, 32'd0);

        // Directed loads, store/readback, errors, boundaries.
        do_op(1, 0, 2, 0, 7, 0);
        check("load2_data", wb_data, 32'd30);
        do_op(0, 1, 3, 77, 1, 1);
        do_op(1, 0, 3, 0, 8, 0);
        check("load3_data", wb_data, 32'd77);
        do_op(1, 0, 7000, 0, 3, 1);
        do_op(1, 1, 1, 5, 4, 1);
        do_op(1, 0, MEM_DEPTH - 1, 0, 5, 0);
        do_op(0, 1, MEM_DEPTH, 9, 6, 0);
        do_op(0, 0, 32'hFFFF_FFF0, 0, 9, 1);

        // Back-to-back pass-through.
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1; ex_addr = 5 + i; ex_rd = 5'(i + 1); ex_regwrite = 1;
            @(negedge clock);
            check("b2b_ex_ready", {31'd0, ex_ready}, 32'd1);
            if (i > 0) check("b2b_wb_data", wb_data, 32'(4 + i));
            @(posedge clock); #1;
        end
        idle_inputs();
        @(negedge clock);
        check("b2b_last", wb_data, 32'd7);

        // Backpressure with a queued load of address 4.
        @(posedge clock); #1;
        ex_valid = 1; ex_addr = 100; ex_rd = 9; ex_regwrite = 1;
        @(posedge clock); #1;
        wb_ready = 0;
        ex_is_load = 1; ex_addr = 4; ex_rd = 12; ex_regwrite = 0;
        held_data = 32'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_ex_ready", {31'd0, ex_ready}, 32'd0);
            check("bp_wb_data", wb_data, held_data);
            check("bp_wb_rd", {27'd0, wb_rd}, 32'd9);
            check("bp_mem_read", {31'd0, mem_read}, 32'd0);
            @(posedge clock); #1;
        end
        wb_ready = 1;
        @(negedge clock);
        check("bp_release_ready", {31'd0, ex_ready}, 32'd1);
        check("bp_release_read", {31'd0, mem_read}, 32'd1);
        @(posedge clock); #1;
        idle_inputs();
        @(posedge clock); #1;
        @(negedge clock);
        ref_ld = sat_inc(ref_ld);
        check("bp_load_data", wb_data, 32'd6);
        check("bp_load_rd", {27'd0, wb_rd}, 32'd12);
        check("bp_load_count", 32'(load_count), 32'(ref_ld));

        // Store counter saturation.
        for (int i = 0; i < 20; i++) do_op(0, 1, 32'(10 + i), $urandom, 5'(i), 0);
        check("store_sat", 32'(store_count), 32'(CNT_MAX));

        // Random mix against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       begin ld = 0; st = 0; end
                1:       begin ld = 1; st = 0; end
                2:       begin ld = 0; st = 1; end
                default: begin ld = 1; st = 1; end
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'(MEM_DEPTH + $urandom_range(0, 1000))
                                            : 32'($urandom_range(0, 31));
            if (!ld && !st) a = $urandom;
            do_op(ld, st, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        // Reset during LOAD_WAIT discards the load.
        @(posedge clock); #1;
        ex_valid = 1; ex_is_load = 1; ex_addr = 5; ex_rd = 3;
        @(negedge clock);
        check("rlw_mem_read", {31'd0, mem_read}, 32'd1);
        @(posedge clock); #1;
        idle_inputs();
        #2 reset_n = 0;
        #1;
        check("rlw_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rlw_load_count", 32'(load_count), 32'd0);
        check("rlw_store_count", 32'(store_count), 32'd0);
        @(posedge clock); #1 reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rlw_no_result", {31'd0, wb_valid}, 32'd0);
            check("rlw_ready", {31'd0, ex_ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
